fir_round_decimate: RTL and testbench
=====================================

// Module: fir_round_decimate
// PURPOSE
//  Output stage directly downstream of the fast FIR. Accepts the full-precision FIR result on each
//  i_ce, applies convergent rounding and saturation down to OW bits, keeps one of every DECIM
//  samples, and delivers it through a 2-entry valid/ready output FIFO to the next consumer.
// PARAMETERS
//  IW     31  input width; equals the FIR output width (2*12+7)
//  OW     16  output width, signed
//  RSHIFT 11  LSBs discarded by rounding; RSHIFT+OW <= IW; RSHIFT=0 bypasses rounding
//  DECIM   4  decimation ratio, >= 1; DECIM=1 keeps every sample
// PORTS
//  i_clk       in   1   clock, all logic rising-edge
//  i_areset_n  in   1   asynchronous, active-low reset
//  i_ce        in   1   input sample strobe, same cycle as i_result is valid
//  i_result    in   IW  signed FIR output
//  i_sync      in   1   with i_ce: keep this sample and restart decimation phase
//  o_valid     out  1   output sample available
//  i_ready     in   1   consumer accepts o_data when o_valid && i_ready
//  o_data      out  OW  signed rounded/saturated sample
//  o_sat       out  1   one-cycle pulse: the kept sample leaving stage 2 was saturated
//  o_overflow  out  1   sticky: a kept sample was dropped because the FIFO was full
//  i_clr_ovf   in   1   synchronous clear of o_overflow
// BEHAVIOUR
//  - Reset (async assert, sync release): o_valid=0, o_data=0, o_sat=0, o_overflow=0, FIFO empty,
//    decimation counter=0, stage-1/2 valid flags=0. Reset mid-stream discards all in-flight data.
//  - Stage 1 (on i_ce): keep = i_sync || (cnt==0); cnt <= i_sync ? (DECIM>1) : (cnt==DECIM-1 ? 0 : cnt+1).
//    First sample after reset is kept. Non-kept samples never enter stage 2.
//  - Rounding, computed in IW-RSHIFT+1 bits: truncated value T = i_result>>>RSHIFT, plus 1 when the
//    dropped bits exceed half, or equal exactly half and T is odd (round-half-to-even). Registered
//    with s1_valid=keep&&i_ce.
//  - Stage 2: saturate the rounded value to [-2^(OW-1), 2^(OW-1)-1]; o_sat pulses the same cycle the
//    saturated word is written into the FIFO (or dropped). s2_valid follows s1_valid by one cycle.
//  - Latency: kept sample on i_ce in cycle N -> o_valid high at cycle N+2 when FIFO was empty.
//  - FIFO: 2 entries, first-word-fall-through on o_data. Push when s2_valid; pop when o_valid&&i_ready.
//    Push and pop same cycle with FIFO full: both occur, no drop. Push into full FIFO without pop:
//    word discarded, o_overflow set; contents unchanged.
//  - i_clr_ovf and a new overflow in the same cycle: o_overflow stays 1 (set wins).
//  - o_data holds its value while o_valid=0 after the last pop; o_data/o_valid never change while
//    o_valid && !i_ready except by reset.
//  - i_ce deassertion freezes stages 1-2 and the counter; FIFO output side keeps draining.
//  - i_sync without i_ce is ignored.
// TESTING
//  - Reset: assert i_areset_n=0 mid-burst -> o_valid=0, o_overflow=0 immediately; next kept sample is
//    first i_ce after release.
//  - Decimation: DECIM=4, i_ready=1, inputs 0..11 <<RSHIFT on consecutive i_ce -> outputs 0,4,8; each
//    o_valid exactly 2 cycles after its i_ce.
//  - Rounding: RSHIFT=11, i_result = 2.5, 3.5, -2.5, 2.5+1lsb (in units of 2^11) -> o_data 2,4,-2,3.
//  - Saturation: i_result = 2^(IW-1)-1 and -2^(IW-1) -> o_data 32767 / -32768 with o_sat pulse each.
//  - Backpressure: i_ready=0, DECIM=1, 3 samples -> FIFO holds first two, third dropped, o_overflow=1;
//    i_ready=1 then returns samples 1,2 in order; i_clr_ovf clears flag.
//  - Sync: i_sync with i_ce on sample 2 of a DECIM=4 stream -> samples 0,2,6,10 kept.

Source files
------------

// File: rtl/fir_round_decimate.sv
// Output stage behind the fast FIR: convergent rounding, saturation to OW bits,
// 1-in-DECIM decimation and a 2-entry first-word-fall-through valid/ready FIFO.
module fir_round_decimate #(
  parameter int IW     = 31,
  parameter int OW     = 16,
  parameter int RSHIFT = 11,
  parameter int DECIM  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_areset_n,
  input  logic                 i_ce,
  input  logic [IW-1:0]        i_result,
  input  logic                 i_sync,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [OW-1:0] o_data,
  output logic                 o_sat,
  output logic                 o_overflow,
  input  logic                 i_clr_ovf
);

  // One guard bit above the truncated value so the +1 of rounding cannot wrap.
  localparam int RW = IW - RSHIFT + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] cnt;
  logic          keep;
  logic [RW-1:0] rounded;
  logic          s1_valid;
  logic [RW-1:0] s1_data;
  logic          sat_hi;
  logic          sat_lo;
  logic [OW-1:0] sat_word;
  logic          push;
  logic          pop;
  logic [1:0]    count;
  logic [OW-1:0] tail;

  assign keep = i_sync || (cnt == '0);

  generate
    if (RSHIFT == 0) begin : g_no_round
      assign rounded = {i_result[IW-1], i_result};
    end else begin : g_round
      localparam logic [RSHIFT-1:0] HALF = RSHIFT'(1) << (RSHIFT - 1);
      logic [RW-1:0]     trunc;
      logic [RSHIFT-1:0] dropped;
      logic              round_up;
      assign trunc    = {i_result[IW-1], i_result[IW-1:RSHIFT]};
      assign dropped  = i_result[RSHIFT-1:0];
      // Ties go to the even neighbour so long-run rounding error averages to zero.
      assign round_up = (dropped > HALF) || ((dropped == HALF) && trunc[0]);
      assign rounded  = trunc + RW'(round_up);
    end
  endgenerate

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= i_ce && keep;
      if (i_ce) begin
        if (i_sync)                       cnt <= CW'((DECIM > 1) ? 1 : 0);
        else if (cnt == CW'(DECIM - 1))   cnt <= '0;
        else                              cnt <= cnt + CW'(1);
        if (keep) s1_data <= rounded;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    sat_hi   = 1'b0;
    sat_lo   = 1'b0;
    sat_word = s1_data[OW-1:0];
    sat_hi   = !s1_data[RW-1] && (|s1_data[RW-2:OW-1]);
    sat_lo   = s1_data[RW-1] && !(&s1_data[RW-2:OW-1]);
    if (sat_hi)      sat_word = {1'b0, {(OW-1){1'b1}}};
    else if (sat_lo) sat_word = {1'b1, {(OW-1){1'b0}}};
  end

  assign push    = s1_valid;
  assign pop     = o_valid && i_ready;
  assign o_valid = (count != 2'd0);

  // o_data is the FIFO head register, so it holds the last word once drained.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      count      <= 2'd0;
      o_data     <= '0;
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_sat <= push && (sat_hi || sat_lo);
      case (count)
        2'd0: if (push) begin
          o_data <= sat_word;
          count  <= 2'd1;
        end
        2'd1: begin
          if (push && pop)  o_data <= sat_word;
          else if (push)    count  <= 2'd2;
          else if (pop)     count  <= 2'd0;
        end
        2'd2: if (pop) begin
          o_data <= tail;
          count  <= push ? 2'd2 : 2'd1;
        end
        default: count <= 2'd0;
      endcase
      if (push && (count == 2'd2) && !pop) o_overflow <= 1'b1;
      else if (i_clr_ovf)                  o_overflow <= 1'b0;
    end
  end

  // NOTE: the second FIFO slot is storage qualified by count, so it carries no
  // reset; only the control state and the visible outputs are reset.
  always_ff @(posedge i_clk) begin
    if (push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop)))
      tail <= sat_word;
  end

endmodule

// File: tb/tb_fir_round_decimate.sv
// Directed bench: two instances (DECIM=4 and DECIM=1) share stimulus; each step
// checks outputs #1 after the rising edge against hand-computed values.
module tb_fir_round_decimate;

  localparam int IW = 31;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_ce;
  logic [IW-1:0]        i_result;
  logic                 i_sync;
  logic                 i_ready;
  logic                 i_clr_ovf;

  logic                 d4_valid, d4_sat, d4_ovf;
  logic signed [OW-1:0] d4_data;
  logic                 d1_valid, d1_sat, d1_ovf;
  logic signed [OW-1:0] d1_data;

  int total = 0;
  int bad   = 0;

  fir_round_decimate #(.IW(IW), .OW(OW), .RSHIFT(11), .DECIM(4)) dut (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(i_ce), .i_result(i_result),
    .i_sync(i_sync), .o_valid(d4_valid), .i_ready(i_ready), .o_data(d4_data),
    .o_sat(d4_sat), .o_overflow(d4_ovf), .i_clr_ovf(i_clr_ovf)
  );

  fir_round_decimate #(.IW(IW), .OW(OW), .RSHIFT(11), .DECIM(1)) dut1 (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(i_ce), .i_result(i_result),
    .i_sync(i_sync), .o_valid(d1_valid), .i_ready(i_ready), .o_data(d1_data),
    .o_sat(d1_sat), .o_overflow(d1_ovf), .i_clr_ovf(i_clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_ce  = 1'b0;
    i_sync = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Sample on i_ce in cycle N; returns in cycle N+2 where the word should be visible.
  task automatic send_and_wait(input logic [IW-1:0] v);
    i_ce     = 1'b1;
    i_sync   = 1'b1;
    i_result = v;
    tick();
    i_ce   = 1'b0;
    i_sync = 1'b0;
    tick();
  endtask

  initial begin
    int  k;
    logic exp_v;

    rst_n     = 1'b0;
    i_ce      = 1'b0;
    i_result  = '0;
    i_sync    = 1'b0;
    i_ready   = 1'b1;
    i_clr_ovf = 1'b0;
    tick();
    tick();
    check("rst_valid", d4_valid, 1'b0);
    check("rst_data",  d4_data,  0);
    check("rst_sat",   d4_sat,   1'b0);
    check("rst_ovf",   d4_ovf,   1'b0);
    rst_n = 1'b1;

    // Decimation by 4: inputs 0..11 keep 0,4,8, each visible exactly 2 cycles later.
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        i_ce     = 1'b1;
        i_result = IW'(i << 11);
      end
      tick();
      i_ce  = 1'b0;
      k     = i - 1;
      exp_v = (k >= 0) && (k <= 8) && (k % 4 == 0);
      check("decim_valid", d4_valid, exp_v);
      if (exp_v) check("decim_data", d4_data, k);
    end
    check("hold_data_after_drain", d4_data, 8);

    // Convergent rounding: 2.5, 3.5, -2.5, 2.5+1lsb -> 2, 4, -2, 3.
    send_and_wait(31'd5120);
    check("round_2p5_valid", d4_valid, 1'b1);
    check("round_2p5", d4_data, 2);
    check("round_2p5_sat", d4_sat, 1'b0);
    tick();
    send_and_wait(31'd7168);
    check("round_3p5", d4_data, 4);
    tick();
    send_and_wait(-31'sd5120);
    check("round_m2p5", d4_data, -2);
    tick();
    send_and_wait(31'd5121);
    check("round_2p5_plus", d4_data, 3);
    tick();

    // Saturation at both rails, then exact in-range rails without o_sat.
    send_and_wait(31'h3FFF_FFFF);
    check("sat_pos_data", d4_data, 32767);
    check("sat_pos_pulse", d4_sat, 1'b1);
    tick();
    check("sat_pulse_ends", d4_sat, 1'b0);
    send_and_wait(31'h4000_0000);
    check("sat_neg_data", d4_data, -32768);
    check("sat_neg_pulse", d4_sat, 1'b1);
    tick();
    send_and_wait(31'h03FF_F800);
    check("max_nosat_data", d4_data, 32767);
    check("max_nosat_pulse", d4_sat, 1'b0);
    tick();
    send_and_wait(31'h7C00_0000);
    check("min_nosat_data", d4_data, -32768);
    check("min_nosat_pulse", d4_sat, 1'b0);
    tick();

    // Backpressure on the DECIM=1 instance: third sample dropped, overflow sticks.
    do_reset();
    i_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      i_ce     = 1'b1;
      i_result = IW'(j << 11);
      tick();
    end
    i_ce = 1'b0;
    tick();
    tick();
    check("bp_valid", d1_valid, 1'b1);
    check("bp_head", d1_data, 1);
    check("bp_ovf", d1_ovf, 1'b1);
    i_ready = 1'b1;
    tick();
    check("bp_second_valid", d1_valid, 1'b1);
    check("bp_second", d1_data, 2);
    tick();
    check("bp_empty", d1_valid, 1'b0);
    check("bp_hold", d1_data, 2);
    check("bp_ovf_sticky", d1_ovf, 1'b1);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    check("bp_ovf_cleared", d1_ovf, 1'b0);

    // Clear coinciding with a new drop: set wins.
    i_ready = 1'b0;
    for (int j = 5; j <= 7; j++) begin
      i_ce     = 1'b1;
      i_result = IW'(j << 11);
      tick();
    end
    i_ce      = 1'b0;
    i_clr_ovf = 1'b1;
    tick();
    check("ovf_set_wins", d1_ovf, 1'b1);
    tick();
    i_clr_ovf = 1'b0;
    check("ovf_clr_again", d1_ovf, 1'b0);

    // Push and pop on a full FIFO in the same cycle: nothing dropped.
    i_ce     = 1'b1;
    i_result = IW'(8 << 11);
    tick();
    i_ce    = 1'b0;
    i_ready = 1'b1;
    tick();
    check("full_pushpop_data", d1_data, 6);
    check("full_pushpop_ovf", d1_ovf, 1'b0);
    tick();
    check("full_pushpop_next_valid", d1_valid, 1'b1);
    check("full_pushpop_next", d1_data, 8);
    tick();
    check("full_pushpop_empty", d1_valid, 1'b0);

    // Sync on sample 2 of a DECIM=4 stream: keep 0, 2, 6, 10.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        i_ce     = 1'b1;
        i_sync   = (i == 2);
        i_result = IW'(i << 11);
      end
      tick();
      i_ce   = 1'b0;
      i_sync = 1'b0;
      k      = i - 1;
      exp_v  = (k == 0) || (k == 2) || (k == 6) || (k == 10);
      check("sync_valid", d4_valid, exp_v);
      if (exp_v) check("sync_data", d4_data, k);
    end

    // Reset asserted mid-burst with a full, overflowed FIFO.
    i_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      i_ce     = 1'b1;
      i_result = IW'((j + 40) << 11);
      tick();
    end
    check("pre_rst_ovf", d1_ovf, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_d1_valid", d1_valid, 1'b0);
    check("midrst_d1_ovf", d1_ovf, 1'b0);
    check("midrst_d4_valid", d4_valid, 1'b0);
    i_ce = 1'b0;
    tick();
    rst_n   = 1'b1;
    i_ready = 1'b1;
    tick();
    check("post_rst_no_stale", d4_valid, 1'b0);
    for (int j = 0; j < 3; j++) begin
      i_ce     = 1'b1;
      i_result = IW'((20 + j) << 11);
      tick();
      i_ce = 1'b0;
      if (j == 1) begin
        check("post_rst_first_valid", d4_valid, 1'b1);
        check("post_rst_first_data", d4_data, 20);
      end
      if (j == 2) check("post_rst_skip", d4_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
